mux_arb_nway: RTL and testbench

// - Parametrised N-input, W-bit registered multiplexer with valid/ready handshake on every input and on the output.
// - Successor to the 16-bit 2:1 combinational mux.
// - Source choice per transfer: either an explicit select (fixed mode) or a fair round-robin arbiter (RR mode).
// - Sits between the register-file/ALU result paths and the writeback/bus stage; one output register stage.

---
 rtl/mux_arb_nway_if.sv | 29 ++
 rtl/mux_arb_nway.sv | 104 ++++++++++
 tb/tb_mux_arb_nway.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mux_arb_nway_if.sv
// Bundle of the mux/arbiter's channel inputs, the registered output port and the mode controls.
// The slave modport is the mux itself; the master modport is whoever drives the channels and sinks the output.
interface mux_arb_nway_if #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
);
  logic                    rr_en;
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_src;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;
  logic [SEL_W-1:0]        rr_ptr;

  modport slave (
    input  rr_en, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_src, out_valid, sel_err, rr_ptr
  );

  modport master (
    output rr_en, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_src, out_valid, sel_err, rr_ptr
  );
endinterface

// File: rtl/mux_arb_nway.sv
// N-input registered multiplexer with a fixed-select or round-robin source choice.
// One output register stage; rr_ptr is exposed on the interface for observation.
module mux_arb_nway #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_arb_nway_if.slave bus
);

  // Handshake: a beat moves on a port in any cycle where valid && ready are both
  // high at the rising edge; valid never depends on ready, out_* are registered.

  logic                 load_en;
  logic                 sel_oob;
  logic                 gnt_vld;
  logic [SEL_W-1:0]     gnt;
  logic [WIDTH-1:0]     gnt_data;
  logic                 gnt_in_valid;
  logic                 xfer;
  logic [2*NUM_IN-1:0]  valid_dbl;
  logic [2*NUM_IN-1:0]  valid_rot;
  logic [31:0]          pos;

  logic [WIDTH-1:0]     out_data_q;
  logic [SEL_W-1:0]     out_src_q;
  logic                 out_valid_q;
  logic                 sel_err_q;
  logic [SEL_W-1:0]     rr_ptr_q;

  assign load_en   = !out_valid_q || bus.out_ready;
  assign sel_oob   = 32'(bus.sel) >= 32'(NUM_IN);
  assign valid_dbl = {bus.in_valid, bus.in_valid};
  // Rotating by rr_ptr puts the highest-priority channel at bit 0.
  assign valid_rot = valid_dbl >> rr_ptr_q;

  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    pos     = '0;
    if (!bus.rr_en) begin
      if (!sel_oob) begin
        gnt     = bus.sel;
        gnt_vld = 1'b1;
      end
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (!gnt_vld && valid_rot[k]) begin
          pos = 32'(rr_ptr_q) + 32'(k);
          if (pos >= 32'(NUM_IN)) pos = pos - 32'(NUM_IN);
          gnt     = SEL_W'(pos);
          gnt_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_data     = '0;
    gnt_in_valid = 1'b0;
    bus.in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt == SEL_W'(i)) begin
        gnt_data     = bus.in_data[i*WIDTH +: WIDTH];
        gnt_in_valid = bus.in_valid[i];
      end
      bus.in_ready[i] = rst_n && gnt_vld && load_en && (gnt == SEL_W'(i));
    end
  end

  assign xfer = gnt_vld && gnt_in_valid && load_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      sel_err_q <= !bus.rr_en && sel_oob;
      if (load_en) begin
        out_valid_q <= xfer;
        if (xfer) begin
          out_data_q <= gnt_data;
          out_src_q  <= gnt;
        end
      end
      if (xfer && bus.rr_en) begin
        if (32'(gnt) == 32'(NUM_IN - 1)) rr_ptr_q <= '0;
        else                             rr_ptr_q <= gnt + SEL_W'(1);
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel_err   = sel_err_q;
  assign bus.rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_mux_arb_nway.sv
// Directed bench for mux_arb_nway: a 4-channel instance (fixed, RR, backpressure, reset)
// and a 3-channel instance (out-of-range select); outputs are checked through expected queues.
module tb_mux_arb_nway;

  logic clk;
  logic rst_n;

  mux_arb_nway_if #(.WIDTH(16), .NUM_IN(4), .SEL_W(2)) ia ();
  mux_arb_nway_if #(.WIDTH(16), .NUM_IN(3), .SEL_W(2)) ib ();

  mux_arb_nway #(.WIDTH(16), .NUM_IN(4), .SEL_W(2)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  mux_arb_nway #(.WIDTH(16), .NUM_IN(3), .SEL_W(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_qa[$];
  logic [17:0] exp_qb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [1:0] src, input logic [15:0] data);
    exp_qa.push_back({src, data});
  endtask

  task automatic set_a_data(input logic [15:0] d3, input logic [15:0] d2,
                            input logic [15:0] d1, input logic [15:0] d0);
    ia.in_data = {d3, d2, d1, d0};
  endtask

  // scoreboard monitors: one pop per accepted output beat
  always @(negedge clk) begin
    if (rst_n && ia.out_valid && ia.out_ready) begin
      if (exp_qa.size() == 0) begin
        check("a_unexpected_beat", {14'd0, ia.out_src, ia.out_data}, 32'h3ffff);
      end else begin
        logic [17:0] e;
        e = exp_qa.pop_front();
        check("a_out_src", 32'(ia.out_src), 32'(e[17:16]));
        check("a_out_data", 32'(ia.out_data), 32'(e[15:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ib.out_valid && ib.out_ready) begin
      if (exp_qb.size() == 0) begin
        check("b_unexpected_beat", {14'd0, ib.out_src, ib.out_data}, 32'h3ffff);
      end else begin
        logic [17:0] e;
        e = exp_qb.pop_front();
        check("b_out_src", 32'(ib.out_src), 32'(e[17:16]));
        check("b_out_data", 32'(ib.out_data), 32'(e[15:0]));
      end
    end
  end

  // driver
  initial begin
    rst_n        = 1'b0;
    ia.rr_en     = 1'b0;
    ia.sel       = 2'd2;
    ia.in_data   = '0;
    ia.in_valid  = '0;
    ia.out_ready = 1'b1;
    ib.rr_en     = 1'b0;
    ib.sel       = 2'd0;
    ib.in_data   = '0;
    ib.in_valid  = '0;
    ib.out_ready = 1'b1;

    // reset state
    step();
    step();
    check("rst_out_valid", 32'(ia.out_valid), 32'd0);
    check("rst_out_data", 32'(ia.out_data), 32'd0);
    check("rst_out_src", 32'(ia.out_src), 32'd0);
    check("rst_sel_err", 32'(ia.sel_err), 32'd0);
    check("rst_rr_ptr", 32'(ia.rr_ptr), 32'd0);
    check("rst_in_ready", 32'(ia.in_ready), 32'd0);
    check("rst_b_out_valid", 32'(ib.out_valid), 32'd0);
    rst_n = 1'b1;
    step();

    // fixed select, sel=2
    set_a_data(16'h0003, 16'hBEEF, 16'h0001, 16'h0000);
    ia.in_valid = 4'b0100;
    #1;
    check("fix_in_ready", 32'(ia.in_ready), 32'b0100);
    push_a(2'd2, 16'hBEEF);
    step();
    check("fix_out_valid", 32'(ia.out_valid), 32'd1);
    ia.in_valid = 4'b0000;
    #1;
    check("fix_ready_no_valid", 32'(ia.in_ready), 32'b0100);
    step();
    check("idle_out_valid", 32'(ia.out_valid), 32'd0);
    check("idle_hold_data", 32'(ia.out_data), 32'hBEEF);
    check("idle_hold_src", 32'(ia.out_src), 32'd2);
    check("fix_rr_ptr_kept", 32'(ia.rr_ptr), 32'd0);

    // round robin, all valid: 0,1,2,3,0,1 back to back
    ia.rr_en = 1'b1;
    set_a_data(16'd3, 16'd2, 16'd1, 16'd0);
    ia.in_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      push_a(2'(k % 4), 16'(k % 4));
      step();
      check("rr_out_valid", 32'(ia.out_valid), 32'd1);
    end
    check("rr_ptr_after6", 32'(ia.rr_ptr), 32'd2);
    ia.in_valid = 4'b0000;
    step();

    // sparse valids 1001 starting from rr_ptr=1
    set_a_data(16'hD3D3, 16'h0C2C, 16'h0B1B, 16'hA0A0);
    ia.in_valid = 4'b0001;
    push_a(2'd0, 16'hA0A0);
    step();
    check("sp_rr_ptr_start", 32'(ia.rr_ptr), 32'd1);
    ia.in_valid = 4'b1001;
    #1;
    check("sp_ready_g3", 32'(ia.in_ready), 32'b1000);
    push_a(2'd3, 16'hD3D3);
    step();
    check("sp_rr_ptr_0", 32'(ia.rr_ptr), 32'd0);
    check("sp_ready_g0", 32'(ia.in_ready), 32'b0001);
    push_a(2'd0, 16'hA0A0);
    step();
    check("sp_rr_ptr_1", 32'(ia.rr_ptr), 32'd1);
    check("sp_ready_g3b", 32'(ia.in_ready), 32'b1000);
    push_a(2'd3, 16'hD3D3);
    step();
    check("sp_rr_ptr_end", 32'(ia.rr_ptr), 32'd0);

    // backpressure for 3 clocks with changing inputs
    set_a_data(16'h1003, 16'h1002, 16'h1001, 16'h1000);
    ia.in_valid = 4'b1111;
    #1;
    check("bp_ready_load", 32'(ia.in_ready), 32'b0001);
    push_a(2'd0, 16'h1000);
    step();
    ia.out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      ia.in_valid = 4'b1110 ^ 4'(j);
      set_a_data(16'(16'h5000 + j), 16'(16'h6000 + j), 16'(16'h7000 + j), 16'(16'h8000 + j));
      #1;
      check("bp_in_ready", 32'(ia.in_ready), 32'd0);
      step();
      check("bp_valid_hold", 32'(ia.out_valid), 32'd1);
      check("bp_data_hold", 32'(ia.out_data), 32'h1000);
      check("bp_src_hold", 32'(ia.out_src), 32'd0);
    end
    ia.out_ready = 1'b1;
    ia.in_valid  = 4'b0010;
    set_a_data(16'h0000, 16'h0000, 16'h2222, 16'h0000);
    #1;
    check("bp_release_ready", 32'(ia.in_ready), 32'b0010);
    push_a(2'd1, 16'h2222);
    step();
    check("bp_release_data", 32'(ia.out_data), 32'h2222);
    check("bp_release_src", 32'(ia.out_src), 32'd1);
    ia.in_valid = 4'b0000;
    step();

    // 3-channel instance: out-of-range select, then a legal one
    ib.rr_en    = 1'b0;
    ib.sel      = 2'd3;
    ib.in_data  = {16'h0B22, 16'h0B11, 16'h0B00};
    ib.in_valid = 3'b111;
    #1;
    check("oob_in_ready", 32'(ib.in_ready), 32'd0);
    step();
    check("oob_sel_err", 32'(ib.sel_err), 32'd1);
    check("oob_no_xfer", 32'(ib.out_valid), 32'd0);
    ib.sel = 2'd1;
    #1;
    check("b_sel1_ready", 32'(ib.in_ready), 32'b010);
    exp_qb.push_back({2'd1, 16'h0B11});
    step();
    check("b_sel_err_clr", 32'(ib.sel_err), 32'd0);
    check("b_sel1_valid", 32'(ib.out_valid), 32'd1);
    ib.in_valid = 3'b000;
    step();

    // asynchronous reset while an output is held
    ia.rr_en     = 1'b1;
    ia.out_ready = 1'b0;
    ia.in_valid  = 4'b1111;
    set_a_data(16'h4443, 16'h4442, 16'h4441, 16'h4440);
    step();
    check("mid_out_valid", 32'(ia.out_valid), 32'd1);
    check("mid_rr_ptr", 32'(ia.rr_ptr), 32'd3);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(ia.out_valid), 32'd0);
    check("arst_out_data", 32'(ia.out_data), 32'd0);
    check("arst_rr_ptr", 32'(ia.rr_ptr), 32'd0);
    check("arst_in_ready", 32'(ia.in_ready), 32'd0);
    ia.out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(ia.in_ready), 32'b0001);
    push_a(2'd0, 16'h4440);
    step();
    ia.in_valid = 4'b0000;
    step();
    step();

    check("a_queue_empty", 32'(exp_qa.size()), 32'd0);
    check("b_queue_empty", 32'(exp_qb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
